// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage. Owns the program counter. Issues word reads to a
// multi-cycle instruction ROM over a simple cs/addr/dout/stall handshake, and
// hands {pc, inst} to the decode stage through a registered IF/ID slot. A
// one-entry buffer covers the case where a fetch completes while decode is
// still holding the previous instruction. Branch/jump redirects discard any
// fetched work, including a ROM read that is still in flight.
//
// Parameters
//   RESET_PC      byte address fetched first after reset
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   mem_cs        ROM chip select, held high for a whole request
//   mem_addr      ROM word address, {2'b00, pc[31:2]}
//   mem_din       ROM read data, valid only when mem_cs & ~mem_stall
//   mem_stall     ROM busy; a request completes on the first cycle with
//                 mem_cs=1 and mem_stall=0
//   id_stall      decode cannot accept a new instruction this cycle
//   redirect      branch/jump taken, discard fetched work
//   redirect_pc   new PC, bits [1:0] are ignored
//   if_valid      if_pc/if_inst hold a valid instruction
//   if_pc         byte address of if_inst
//   if_inst       instruction word, zero whenever if_valid is low
//   stall_cycles  saturating count of cycles with mem_cs=1 and mem_stall=1
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  input  logic        mem_stall,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] stall_cycles
);

  // IDLE  : one chip-select-low cycle after reset
  // REQ   : a ROM request is outstanding (chip select high)
  // ABORT : one chip-select-low cycle after a redirect killed a request, so
  //         the ROM drops its partial access before the new address arrives
  // HOLD  : a completed word sits in the buffer behind a stalled decode slot
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q;
  logic        memCs_q;
  logic [31:0] pc_q;
  logic        ifValid_q;
  logic [31:0] ifPc_q;
  logic [31:0] ifInst_q;
  logic [31:0] bufPc_q;
  logic [31:0] bufInst_q;
  logic [31:0] stallCnt_q;
  logic [31:0] stallCnt_d;

  logic        memDone;
  logic [31:0] pcPlus4;
  logic [31:0] targetPc;

  // A request completes on the first cycle the ROM is selected and not busy.
  // Redirect targets are always word aligned; the low two bits are dropped.
  // PC increment wraps silently at the top of the address space.
  assign memDone  = memCs_q & ~mem_stall;
  assign pcPlus4  = pc_q + 32'd4;
  assign targetPc = redirect_pc & 32'hFFFF_FFFC;

  assign mem_cs       = memCs_q;
  assign mem_addr     = {2'b00, pc_q[31:2]};
  assign if_valid     = ifValid_q;
  assign if_pc        = ifPc_q;
  assign if_inst      = ifInst_q;
  assign stall_cycles = stallCnt_q;

  // Fetch state machine. Chip select is a registered output that is raised on
  // every transition into REQ and lowered on every transition out of it, so it
  // never glitches and the address stays stable for the whole request because
  // the PC only moves on the edge that ends a request.
  //
  // In REQ a redirect wins over a completion arriving on the same edge: the
  // returned word belongs to the wrong path and is thrown away. A completion
  // refills the IF/ID slot directly whenever the slot is empty or is being
  // consumed on this edge; otherwise the word is parked in the buffer and the
  // machine stops fetching until decode drains the slot.
  //
  // Whenever the slot is invalidated, the address and data fields are cleared
  // too so decode never sees stale data on an invalid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      memCs_q   <= 1'b0;
      pc_q      <= RESET_PC;
      ifValid_q <= 1'b0;
      ifPc_q    <= 32'h0;
      ifInst_q  <= 32'h0;
      bufPc_q   <= 32'h0;
      bufInst_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            pc_q <= targetPc;
          end
          state_q <= REQ;
          memCs_q <= 1'b1;
        end

        REQ: begin
          if (redirect) begin
            pc_q      <= targetPc;
            ifValid_q <= 1'b0;
            ifPc_q    <= 32'h0;
            ifInst_q  <= 32'h0;
            state_q   <= ABORT;
            memCs_q   <= 1'b0;
          end else if (memDone) begin
            if (!ifValid_q || !id_stall) begin
              ifValid_q <= 1'b1;
              ifPc_q    <= pc_q;
              ifInst_q  <= mem_din;
              pc_q      <= pcPlus4;
            end else begin
              bufPc_q   <= pc_q;
              bufInst_q <= mem_din;
              pc_q      <= pcPlus4;
              state_q   <= HOLD;
              memCs_q   <= 1'b0;
            end
          end else if (!id_stall) begin
            ifValid_q <= 1'b0;
            ifPc_q    <= 32'h0;
            ifInst_q  <= 32'h0;
          end
        end

        ABORT: begin
          if (redirect) begin
            pc_q <= targetPc;
          end
          state_q <= REQ;
          memCs_q <= 1'b1;
        end

        HOLD: begin
          if (redirect) begin
            pc_q      <= targetPc;
            ifValid_q <= 1'b0;
            ifPc_q    <= 32'h0;
            ifInst_q  <= 32'h0;
            bufPc_q   <= 32'h0;
            bufInst_q <= 32'h0;
            state_q   <= REQ;
            memCs_q   <= 1'b1;
          end else if (!id_stall) begin
            ifValid_q <= 1'b1;
            ifPc_q    <= bufPc_q;
            ifInst_q  <= bufInst_q;
            bufPc_q   <= 32'h0;
            bufInst_q <= 32'h0;
            state_q   <= REQ;
            memCs_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          memCs_q <= 1'b0;
        end
      endcase
    end
  end

  // ROM stall counter: counts busy cycles of outstanding requests and sticks
  // at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (memCs_q && mem_stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= 32'h0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. A ROM with programmable latency answers the DUT's
// requests. A transaction-level model of the fetch stage (fetch pointer,
// pending-request countdown, decode slot, one-entry buffer) predicts every
// output, and the outputs are compared against it on every falling edge.
// Directed scenarios pin the model with hand-computed values; randomized
// back-pressure and redirects follow.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] stall_cycles;

  int nVec;
  int nErr;

  // ROM environment state
  int romLat;
  int romCnt;

  // Behavioural model state
  logic [31:0] mPc;
  bit          mFetching;
  int          mWait;
  int          mGap;
  bit          mSlotValid;
  logic [31:0] mSlotPc;
  logic [31:0] mSlotInst;
  bit          mBufValid;
  logic [31:0] mBufPc;
  logic [31:0] mBufInst;
  logic [31:0] mStall;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_cs       (mem_cs),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_stall    (mem_stall),
    .id_stall     (id_stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the ROM at a given word address.
  function automatic logic [31:0] romWord(input logic [31:0] wa);
    return wa ^ 32'hC0DE_0000;
  endfunction

  // ROM: busy for romLat cycles of every request, then returns data for one
  // cycle. Data lines carry garbage whenever the read is not completing.
  always @(*) begin
    mem_stall = mem_cs && (romCnt != romLat);
    mem_din   = (mem_cs && !mem_stall) ? romWord(mem_addr) : (32'hDEAD_BEEF ^ mem_addr);
  end

  // ROM busy counter restarts with every new request.
  always @(posedge clk or posedge rst) begin
    if (rst) romCnt <= 0;
    else if (!mem_cs || !mem_stall) romCnt <= 0;
    else romCnt <= romCnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc        = RESET_PC;
    mFetching  = 1'b0;
    mWait      = 0;
    mGap       = 1;
    mSlotValid = 1'b0;
    mSlotPc    = 32'h0;
    mSlotInst  = 32'h0;
    mBufValid  = 1'b0;
    mBufPc     = 32'h0;
    mBufInst   = 32'h0;
    mStall     = 32'h0;
  endtask

  task automatic startFetch();
    mFetching = 1'b1;
    mWait     = romLat;
  endtask

  // One clock edge of the fetch stage seen as transactions.
  task automatic modelStep(input bit st, input bit rd, input logic [31:0] rpc);
    bit done;
    bit consumed;
    done     = mFetching && (mWait == 0);
    consumed = mSlotValid && !st;
    if (mFetching && mWait != 0 && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
    if (rd) begin
      mPc        = rpc & 32'hFFFF_FFFC;
      mSlotValid = 1'b0;
      mBufValid  = 1'b0;
      if (mFetching) begin
        mFetching = 1'b0;
        mGap      = 1;
      end else if (mGap != 0) begin
        mGap--;
        if (mGap == 0) startFetch();
      end else begin
        startFetch();
      end
    end else if (mFetching) begin
      if (done) begin
        if (!mSlotValid || !st) begin
          mSlotValid = 1'b1;
          mSlotPc    = mPc;
          mSlotInst  = romWord({2'b00, mPc[31:2]});
          mPc        = mPc + 4;
          mWait      = romLat;
        end else begin
          mBufValid = 1'b1;
          mBufPc    = mPc;
          mBufInst  = romWord({2'b00, mPc[31:2]});
          mPc       = mPc + 4;
          mFetching = 1'b0;
        end
      end else begin
        mWait--;
        if (consumed) mSlotValid = 1'b0;
      end
    end else if (mGap != 0) begin
      mGap--;
      if (mGap == 0) startFetch();
    end else if (!st) begin
      mSlotValid = 1'b1;
      mSlotPc    = mBufPc;
      mSlotInst  = mBufInst;
      mBufValid  = 1'b0;
      startFetch();
    end
  endtask

  // Compare every DUT output with the model.
  task automatic checkOutput();
    check("mem_cs", 32'(mem_cs), 32'(mFetching));
    if (mFetching) check("mem_addr", mem_addr, {2'b00, mPc[31:2]});
    check("if_valid", 32'(if_valid), 32'(mSlotValid));
    if (mSlotValid) check("if_pc", if_pc, mSlotPc);
    check("if_inst", if_inst, mSlotValid ? mSlotInst : 32'h0);
    check("stall_cycles", stall_cycles, mStall);
  endtask

  // Drive inputs at a falling edge, advance one clock, compare at the next
  // falling edge.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc);
    id_stall    = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    modelStep(st, rd, rpc);
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic doReset(input int lat);
    #2;
    rst = 1'b1;
    #1;
    check("rst_cs_drop", 32'(mem_cs), 32'h0);
    check("rst_valid_drop", 32'(if_valid), 32'h0);
    id_stall    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    romLat      = lat;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 40 && !if_valid; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    check(name, 32'(if_valid), 32'h1);
  endtask

  initial begin
    nVec        = 0;
    nErr        = 0;
    rst         = 1'b1;
    id_stall    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    romLat      = 8;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
    check("reset_pc_out", if_pc, 32'h0);
    check("reset_cs", 32'(mem_cs), 32'h0);

    // Sequential fetch with an 8-cycle ROM and no back-pressure.
    applyStimulus(1'b0, 1'b0, 32'h0);
    check("cs_rise", 32'(mem_cs), 32'h1);
    check("first_addr", mem_addr, 32'h0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_pc", if_pc, 32'h0);
    check("first_inst", if_inst, 32'hC0DE_0000);
    check("first_stalls", stall_cycles, 32'd8);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    check("second_pc", if_pc, 32'h4);
    check("second_inst", if_inst, 32'hC0DE_0001);

    // Decode stalls: third word is parked in the buffer and fetching stops.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    check("hold_cs", 32'(mem_cs), 32'h0);
    check("hold_pc", if_pc, 32'h4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    check("hold_pc_still", if_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    check("release_pc", if_pc, 32'h8);
    check("release_inst", if_inst, 32'hC0DE_0002);
    check("release_addr", mem_addr, 32'h3);

    // Redirect in the middle of a request.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h23);
    check("abort_cs", 32'(mem_cs), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    check("abort_cs_back", 32'(mem_cs), 32'h1);
    check("redir_addr", mem_addr, 32'h8);
    waitValid("redir_wait");
    check("redir_pc", if_pc, 32'h20);
    check("redir_inst", if_inst, 32'hC0DE_0008);

    // Redirect on the very edge a read completes.
    for (int i = 0; i < 20 && !(mFetching && mWait == 0); i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    check("coinc_valid", 32'(if_valid), 32'h0);
    waitValid("coinc_wait");
    check("coinc_pc", if_pc, 32'h100);

    // Redirect while a word is parked in the buffer.
    for (int i = 0; i < 30 && (mFetching || mGap != 0); i++) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h200);
    check("holdredir_valid", 32'(if_valid), 32'h0);
    check("holdredir_cs", 32'(mem_cs), 32'h1);
    check("holdredir_addr", mem_addr, 32'h80);

    // Asynchronous reset in the middle of a request.
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset(8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    check("post_reset_addr", mem_addr, RESET_PC >> 2);
    check("post_reset_cs", 32'(mem_cs), 32'h1);

    // Randomized back-pressure, redirects and ROM latencies.
    for (int blk = 0; blk < 6; blk++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      doReset($urandom_range(0, 4));
      for (int i = 0; i < 500; i++) begin
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        st  = ($urandom % 10) < 4;
        rd  = ($urandom % 100) < 8;
        rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF4 + ($urandom % 16)) : $urandom;
        applyStimulus(st, rd, rpc);
      end
    end

    // Stall counter saturation.
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset(8);
    force dut.stallCnt_q = 32'hFFFF_FFF0;
    #1;
    release dut.stallCnt_q;
    mStall = 32'hFFFF_FFF0;
    check("sat_preset", stall_cycles, 32'hFFFF_FFF0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    check("sat_stick", stall_cycles, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
